muldiv_seq: RTL and testbench

Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. It reuses the shared 32-bit ALU for every add, subtract and negate instead of carrying its own wide arithmetic. The block sits beside the EX stage. The parent muxes the ALU operand and opcode inputs to this block while `busy` is high, and the HI/LO register file captures `hi`/`lo` when `done` pulses.

---
 rtl/muldiv_seq_pkg.sv | 34 +++
 rtl/muldiv_seq_if.sv | 31 +++
 rtl/muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_muldiv_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the multi-cycle MULT/MULTU/DIV/DIVU sequencer:
// op codes, FSM state encoding and the shared ALU opcodes it drives.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABS_A  = 3'd1,
        S_ABS_B  = 3'd2,
        S_ITER   = 3'd3,
        S_FIX_LO = 3'd4,
        S_FIX_HI = 3'd5,
        S_DONE   = 3'd6
    } md_state_t;

    // Shared ALU opcodes; RSUB computes alu_b - alu_a.
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_RSUB = 4'b1110;

    localparam int unsigned MD_ITERS = 32;

    function automatic logic is_signed_op(input md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Bundle of request/result and shared-ALU signals between the EX stage and muldiv_seq.
interface muldiv_seq_if;
    import muldiv_seq_pkg::*;

    // Handshake: the request (start, op, a, b) is taken on any rising edge where
    // start=1 and busy=0; busy=0 is the ready. done is a one-cycle valid for hi/lo,
    // which then hold until the next accepted start. start while busy is dropped.
    logic        start;
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_s;

    modport master (
        output start, op, a, b, alu_s,
        input  busy, done, hi, lo, alu_a, alu_b, alu_aluc
    );

    modport slave (
        input  start, op, a, b, alu_s,
        output busy, done, hi, lo, alu_a, alu_b, alu_aluc
    );

endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle signed/unsigned multiply and divide, one shared-ALU pass per cycle:
// magnitudes, 32 shift-add / restoring-divide steps, then sign fix-up of lo and hi.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  md,
    output md_state_t    state_dbg
);

    md_state_t   state_q, state_d;
    logic [31:0] hi_q, lo_q, d_q;
    logic [4:0]  cnt_q;
    logic        is_div_q, neg_a_q, neg_b_q, neg_q_q, neg_r_q, lo_zero_q;

    logic        accept;
    logic [31:0] r_shift;
    logic        div_ok;
    logic        mul_carry;
    logic        sgn;

    assign accept    = md.start && (state_q == S_IDLE || state_q == S_DONE);
    assign r_shift   = {hi_q[30:0], lo_q[31]};
    assign div_ok    = hi_q[31] | (r_shift >= d_q);
    assign mul_carry = md.alu_s < hi_q;
    assign sgn       = is_signed_op(md.op);

    assign md.busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign md.done   = (state_q == S_DONE);
    assign md.hi     = hi_q;
    assign md.lo     = lo_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        md.alu_a    = 32'd0;
        md.alu_b    = 32'd0;
        md.alu_aluc = ALU_ADD;
        case (state_q)
            S_IDLE, S_DONE: state_d = accept ? S_ABS_A : S_IDLE;
            S_ABS_A: begin
                md.alu_a    = lo_q;
                md.alu_aluc = neg_a_q ? ALU_RSUB : ALU_ADD;
                state_d     = S_ABS_B;
            end
            S_ABS_B: begin
                // Multiply parked b in lo during ABS_A; divide kept it in d.
                md.alu_a    = is_div_q ? d_q : lo_q;
                md.alu_aluc = neg_b_q ? ALU_RSUB : ALU_ADD;
                state_d     = S_ITER;
            end
            S_ITER: begin
                if (is_div_q) begin
                    md.alu_a    = r_shift;
                    md.alu_b    = d_q;
                    md.alu_aluc = ALU_SUB;
                end else begin
                    md.alu_a    = hi_q;
                    md.alu_b    = lo_q[0] ? d_q : 32'd0;
                end
                if (cnt_q == 5'(MD_ITERS - 1)) state_d = S_FIX_LO;
            end
            S_FIX_LO: begin
                md.alu_a    = lo_q;
                md.alu_aluc = neg_q_q ? ALU_RSUB : ALU_ADD;
                state_d     = S_FIX_HI;
            end
            S_FIX_HI: begin
                md.alu_a = hi_q;
                if (is_div_q) begin
                    md.alu_aluc = neg_r_q ? ALU_RSUB : ALU_ADD;
                end else if (neg_q_q) begin
                    // 64-bit negate: the +1 only carries into hi when lo was zero.
                    if (lo_zero_q) begin
                        md.alu_aluc = ALU_RSUB;
                    end else begin
                        md.alu_b    = 32'hFFFF_FFFF;
                        md.alu_aluc = ALU_XOR;
                    end
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            d_q       <= 32'd0;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            lo_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        lo_q     <= md.a;
                        d_q      <= md.b;
                        hi_q     <= 32'd0;
                        cnt_q    <= 5'd0;
                        is_div_q <= md.op[1];
                        neg_a_q  <= sgn & md.a[31];
                        neg_b_q  <= sgn & md.b[31];
                        neg_q_q  <= sgn & (md.a[31] ^ md.b[31]);
                        neg_r_q  <= sgn & md.a[31];
                    end
                end
                S_ABS_A: begin
                    if (is_div_q) begin
                        lo_q <= md.alu_s;
                    end else begin
                        d_q  <= md.alu_s;
                        lo_q <= d_q;
                    end
                end
                S_ABS_B: begin
                    if (is_div_q) d_q  <= md.alu_s;
                    else          lo_q <= md.alu_s;
                end
                S_ITER: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (is_div_q) begin
                        hi_q <= div_ok ? md.alu_s : r_shift;
                        lo_q <= {lo_q[30:0], div_ok};
                    end else begin
                        hi_q <= {mul_carry, md.alu_s[31:1]};
                        lo_q <= {md.alu_s[0], lo_q[31:1]};
                    end
                end
                S_FIX_LO: begin
                    lo_q      <= md.alu_s;
                    lo_zero_q <= (lo_q == 32'd0);
                end
                S_FIX_HI: hi_q <= md.alu_s;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: ALU model, 64-bit arithmetic reference,
// directed corner cases, random back-to-back ops, ignored starts and mid-op reset.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic      clk;
    logic      rst;
    md_state_t state_dbg;
    int        n_cmp;
    int        n_err;
    logic [63:0] exp_q[$];

    muldiv_seq_if md();

    muldiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .md        (md.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shared ALU model
    always_comb begin
        case (md.alu_aluc)
            ALU_ADD:  md.alu_s = md.alu_a + md.alu_b;
            ALU_SUB:  md.alu_s = md.alu_a - md.alu_b;
            ALU_XOR:  md.alu_s = md.alu_a ^ md.alu_b;
            ALU_RSUB: md.alu_s = md.alu_b - md.alu_a;
            default:  md.alu_s = 32'd0;
        endcase
    end

    // reference: {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = 64'(sa * sb); return p; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
            2'b10: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // driver: issue one op, wait (bounded) for done; optional stray start at cycle glitch_at
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_at, output logic [63:0] res, output int lat,
                         output logic busy_after);
        @(negedge clk);
        md.start = 1'b1;
        md.op    = md_op_t'(op);
        md.a     = a;
        md.b     = b;
        @(posedge clk);
        #1;
        md.start   = 1'b0;
        busy_after = md.busy;
        md.a       = $urandom;
        md.b       = $urandom;
        lat        = -1;
        for (int i = 1; i <= 100; i++) begin
            if (i == glitch_at) begin
                md.start = 1'b1;
                md.op    = md_op_t'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
            md.start = 1'b0;
            if (md.done) begin
                lat = i;
                break;
            end
        end
        res = {md.hi, md.lo};
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        md.start = 1'b0;
        md.op    = MD_MULT;
        md.a     = 32'd0;
        md.b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", md.busy); end
        n_cmp++; if (md.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", md.done); end
        n_cmp++; if ({md.hi, md.lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got=%h exp=0", {md.hi, md.lo}); end
        n_cmp++; if (state_dbg !== S_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_IDLE); end
        n_cmp++; if ({md.alu_a, md.alu_b, md.alu_aluc} !== {64'd0, ALU_ADD}) begin
            n_err++; $display("FAIL reset_alu got=%h/%h/%h exp=0/0/%h", md.alu_a, md.alu_b, md.alu_aluc, ALU_ADD);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops[7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00};
        logic [31:0] as[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'h1234_5678, 32'h0001_0000};
        logic [31:0] bs[7]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd2, 32'd7, 32'd0, 32'hFFFF_0000};
        logic [63:0] want[7] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1, 64'h4000_0000_0000_0000,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E, 64'h1234_5678_FFFF_FFFF,
                                 64'hFFFF_FFFF_0000_0000};
        logic [63:0] res, exp_v;
        int lat;
        logic bz;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(want[i]);
            do_op(ops[i], as[i], bs[i], 0, res, lat, bz);
            exp_v = exp_q.pop_front();
            n_cmp++; if (res !== exp_v) begin n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, exp_v); end
            n_cmp++; if (lat !== 36) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=36", i, lat); end
            n_cmp++; if (bz !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy got=%b exp=1", i, bz); end
            @(posedge clk);
            #1;
            n_cmp++; if (md.done !== 1'b0 || {md.hi, md.lo} !== exp_v) begin
                n_err++; $display("FAIL dir%0d_hold done=%b got=%h exp=%h", i, md.done, {md.hi, md.lo}, exp_v);
            end
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_random();
        logic [63:0] res, exp_v;
        logic [1:0]  op;
        logic [31:0] a, b;
        int lat;
        logic bz;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                0: b = b >> $urandom_range(1, 31);
                1: a = a >> $urandom_range(1, 31);
                2: a = 32'h8000_0000;
                3: b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
                default: ;
            endcase
            if (op[1] && b == 32'd0) b = 32'd3;
            exp_q.push_back(ref_md(op, a, b));
            do_op(op, a, b, 0, res, lat, bz);
            exp_v = exp_q.pop_front();
            n_cmp++; if (res !== exp_v || lat !== 36) begin
                n_err++; $display("FAIL rand%0d op=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=36", n, op, a, b, res, lat, exp_v);
            end
        end
    endtask

    task automatic test_busy_start();
        int glitch[3] = '{2, 17, 35};
        logic [63:0] res, exp_v;
        int lat;
        logic bz;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ref_md(2'b10, 32'hFFFF_F000, 32'd13));
            do_op(2'b10, 32'hFFFF_F000, 32'd13, glitch[i], res, lat, bz);
            exp_v = exp_q.pop_front();
            n_cmp++; if (res !== exp_v || lat !== 36) begin
                n_err++; $display("FAIL busy_start%0d got=%h lat=%0d exp=%h lat=36", i, res, lat, exp_v);
            end
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] res, exp_v;
        int lat;
        logic bz;
        @(negedge clk);
        md.start = 1'b1;
        md.op    = MD_MULTU;
        md.a     = 32'hDEAD_BEEF;
        md.b     = 32'h1234_5678;
        @(posedge clk);
        #1;
        md.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (md.busy !== 1'b0 || md.done !== 1'b0) begin
            n_err++; $display("FAIL midrst_flags busy=%b done=%b exp=0/0", md.busy, md.done);
        end
        n_cmp++; if ({md.hi, md.lo} !== 64'd0) begin n_err++; $display("FAIL midrst_hilo got=%h exp=0", {md.hi, md.lo}); end
        n_cmp++; if (state_dbg !== S_IDLE) begin n_err++; $display("FAIL midrst_state got=%0d exp=%0d", state_dbg, S_IDLE); end
        rst = 1'b0;
        exp_q.push_back(ref_md(2'b00, 32'h7654_3210, 32'hFEDC_BA98));
        do_op(2'b00, 32'h7654_3210, 32'hFEDC_BA98, 0, res, lat, bz);
        exp_v = exp_q.pop_front();
        n_cmp++; if (res !== exp_v || lat !== 36) begin
            n_err++; $display("FAIL midrst_fresh got=%h lat=%0d exp=%h lat=36", res, lat, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, exp_v;
        int lat;
        logic bz;
        repeat (2) @(posedge clk);
        exp_q.push_back(ref_md(2'b11, 32'hFFFF_FFFF, 32'd10));
        do_op(2'b11, 32'hFFFF_FFFF, 32'd10, 0, res, lat, bz);
        exp_v = exp_q.pop_front();
        n_cmp++; if (res !== exp_v) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", res, exp_v); end
        n_cmp++; if (state_dbg !== S_DONE) begin n_err++; $display("FAIL b2b_in_done got=%0d exp=%0d", state_dbg, S_DONE); end
        exp_q.push_back(ref_md(2'b00, 32'h8000_0000, 32'hFFFF_FFFF));
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat, bz);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bz !== 1'b1) begin n_err++; $display("FAIL b2b_accept busy=%b exp=1", bz); end
        n_cmp++; if (res !== exp_v || lat !== 36) begin
            n_err++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=36", res, lat, exp_v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
